// File: rtl/cp0_commit.sv
// CP0 register file and precise-exception commit unit at the write-back end of the pipeline.
// Records exceptions/ERET, runs Count/Compare, and raises a combinational flush with the redirect PC.
module cp0_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_cp0_ex,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_bd,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_eret,
  input  logic [5:0]  ext_int,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        int_flush,
  output logic [31:0] flush_pc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [3:0] DIV_LAST      = 4'(COUNT_DIV - 1);

  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic        ti;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [3:0]  div;

  logic [7:0]  ip;
  logic        int_pending;
  logic        take_exc;
  logic        take_eret;
  logic        take_mtc0;
  logic [4:0]  commit_code;
  logic        ti_set;
  logic        ti_next;

  assign ip          = {ip_hw, ip_sw};
  assign int_pending = ie & ~exl & (|(im & ip));

  // Exception (incl. interrupt) outranks ERET, which outranks MTC0.
  assign take_exc    = wb_valid & (wb_cp0_ex | int_pending);
  assign take_eret   = wb_valid & ~take_exc & wb_eret;
  assign take_mtc0   = wb_valid & ~take_exc & ~wb_eret & wb_cp0_we;
  assign commit_code = int_pending ? 5'd0 : wb_excode;

  // MTC0 Compare clears TI and wins over a same-cycle match.
  assign ti_set  = (count == compare) && (compare != 32'd0);
  assign ti_next = (take_mtc0 && wb_cp0_addr == ADDR_COMPARE) ? 1'b0 : (ti | ti_set);

  assign cp0_status = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign cp0_cause  = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
  assign cp0_epc    = epc;

  assign int_flush = ~reset & (take_exc | take_eret);

  always_comb begin
    flush_pc = 32'd0;
    if (int_flush) flush_pc = take_exc ? EXC_VECTOR : epc;
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      ADDR_BADVADDR: cp0_rdata = badvaddr;
      ADDR_COUNT:    cp0_rdata = count;
      ADDR_COMPARE:  cp0_rdata = compare;
      ADDR_STATUS:   cp0_rdata = cp0_status;
      ADDR_CAUSE:    cp0_rdata = cp0_cause;
      ADDR_EPC:      cp0_rdata = epc;
      default:       cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 8'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ti       <= 1'b0;
      ip_hw    <= 6'd0;
      ip_sw    <= 2'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
      badvaddr <= 32'd0;
      count    <= 32'd0;
      compare  <= 32'd0;
      div      <= 4'd0;
    end else begin
      ti    <= ti_next;
      // The timer line uses the updated TI so a fresh match is visible as IP7 together with TI.
      ip_hw <= {ext_int[5] | ti_next, ext_int[4:0]};

      if (take_mtc0 && wb_cp0_addr == ADDR_COUNT) begin
        count <= wb_wdata;
        div   <= 4'd0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= 4'd0;
      end else begin
        div   <= div + 4'd1;
      end

      if (take_exc) begin
        if (!exl) begin
          epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          bd  <= wb_bd;
        end
        exl      <= 1'b1;
        exc_code <= commit_code;
        if (commit_code == 5'd4 || commit_code == 5'd5) badvaddr <= wb_badvaddr;
      end else if (take_eret) begin
        exl <= 1'b0;
      end else if (take_mtc0) begin
        case (wb_cp0_addr)
          ADDR_COMPARE: compare <= wb_wdata;
          ADDR_STATUS: begin
            im  <= wb_wdata[15:8];
            exl <= wb_wdata[1];
            ie  <= wb_wdata[0];
          end
          ADDR_CAUSE:   ip_sw <= wb_wdata[9:8];
          ADDR_EPC:     epc   <= wb_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_commit.sv
// Self-checking bench for cp0_commit: directed scenarios plus randomized commits against a behavioural CP0 model.
module tb_cp0_commit;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          DIV = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_cp0_ex;
  logic [4:0]  wb_excode;
  logic [31:0] wb_badvaddr;
  logic        wb_bd;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_addr;
  logic [31:0] wb_wdata;
  logic        wb_eret;
  logic [5:0]  ext_int;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        int_flush;
  logic [31:0] flush_pc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_commit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_cp0_ex(wb_cp0_ex), .wb_excode(wb_excode), .wb_badvaddr(wb_badvaddr),
    .wb_bd(wb_bd), .wb_cp0_we(wb_cp0_we), .wb_cp0_addr(wb_cp0_addr),
    .wb_wdata(wb_wdata), .wb_eret(wb_eret), .ext_int(ext_int),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .int_flush(int_flush),
    .flush_pc(flush_pc), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc)
  );

  always #5 clk = ~clk;

  // Behavioural model of the architectural CP0 state.
  logic [7:0]  m_im = '0;
  logic        m_exl = 1'b0, m_ie = 1'b0, m_bd = 1'b0, m_ti = 1'b0;
  logic [7:0]  m_ip = '0;
  logic [4:0]  m_exc = '0;
  logic [31:0] m_epc = '0, m_bad = '0, m_count = '0, m_cmp = '0;
  int          m_div = 0;

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 8) | (32'(m_exc) << 2);
  endfunction

  function automatic logic m_pending();
    return m_ie && !m_exl && ((m_im & m_ip) != 8'd0);
  endfunction

  function automatic logic m_flush();
    return !reset && wb_valid && (wb_cp0_ex || m_pending() || wb_eret);
  endfunction

  function automatic logic [31:0] m_flush_pc();
    if (!m_flush()) return 32'd0;
    return (wb_cp0_ex || m_pending()) ? VEC : m_epc;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_cmp;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic pend, do_exc, do_eret, do_mtc, new_ti;
    logic [4:0] code;
    if (reset) begin
      m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ip = '0; m_exc = '0;
      m_epc = '0; m_bad = '0; m_count = '0; m_cmp = '0; m_div = 0;
      return;
    end
    pend    = m_pending();
    do_exc  = wb_valid && (wb_cp0_ex || pend);
    do_eret = wb_valid && !do_exc && wb_eret;
    do_mtc  = wb_valid && !do_exc && !wb_eret && wb_cp0_we;
    new_ti  = m_ti || (m_count == m_cmp && m_cmp != 0);
    if (do_mtc && wb_cp0_addr == 5'd11) new_ti = 1'b0;
    if (do_mtc && wb_cp0_addr == 5'd9) begin
      m_count = wb_wdata; m_div = 0;
    end else begin
      m_div = m_div + 1;
      if (m_div == DIV) begin m_div = 0; m_count = m_count + 1; end
    end
    m_ti = new_ti;
    m_ip[7:2] = {ext_int[5] | new_ti, ext_int[4:0]};
    if (do_exc) begin
      code = pend ? 5'd0 : wb_excode;
      if (!m_exl) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_bd  = wb_bd;
      end
      m_exl = 1'b1;
      m_exc = code;
      if (code == 5'd4 || code == 5'd5) m_bad = wb_badvaddr;
    end else if (do_eret) begin
      m_exl = 1'b0;
    end else if (do_mtc) begin
      case (wb_cp0_addr)
        5'd11: m_cmp = wb_wdata;
        5'd12: begin m_im = wb_wdata[15:8]; m_exl = wb_wdata[1]; m_ie = wb_wdata[0]; end
        5'd13: m_ip[1:0] = wb_wdata[9:8];
        5'd14: m_epc = wb_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; wb_valid = 0; wb_pc = 0; wb_cp0_ex = 0; wb_excode = 0;
    wb_badvaddr = 0; wb_bd = 0; wb_cp0_we = 0; wb_cp0_addr = 0; wb_wdata = 0;
    wb_eret = 0; ext_int = 0; cp0_raddr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    clear_inputs();
    wb_valid = 1; wb_cp0_we = 1; wb_cp0_addr = a; wb_wdata = d;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; wb_valid = 1; wb_cp0_ex = 1;
    tick(); tick();
    #1;
    n_cmp++; if (int_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %0b want 0", int_flush); end
    tick();
    clear_inputs();
    cp0_raddr = 5'd12;
    #1;
    n_cmp++; if (cp0_status !== 32'h0040_0000) begin n_bad++; $display("FAIL reset_status got %h want 00400000", cp0_status); end
    n_cmp++; if (cp0_cause !== 32'd0) begin n_bad++; $display("FAIL reset_cause got %h want 0", cp0_cause); end
    n_cmp++; if (cp0_epc !== 32'd0) begin n_bad++; $display("FAIL reset_epc got %h want 0", cp0_epc); end
    n_cmp++; if (int_flush !== 1'b0 || flush_pc !== 32'd0) begin n_bad++; $display("FAIL reset_out got %0b/%h want 0/0", int_flush, flush_pc); end
    n_cmp++; if (cp0_rdata !== 32'h0040_0000) begin n_bad++; $display("FAIL reset_read12 got %h want 00400000", cp0_rdata); end
  endtask

  task automatic test_syscall();
    clear_inputs();
    wb_valid = 1; wb_cp0_ex = 1; wb_excode = 5'd8; wb_pc = 32'hBFC0_0100; wb_bd = 1;
    #1;
    n_cmp++; if (int_flush !== 1'b1 || flush_pc !== VEC) begin n_bad++; $display("FAIL syscall_flush got %0b/%h want 1/%h", int_flush, flush_pc, VEC); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (cp0_epc !== 32'hBFC0_00FC) begin n_bad++; $display("FAIL syscall_epc got %h want bfc000fc", cp0_epc); end
    n_cmp++; if (cp0_cause !== 32'h8000_0020) begin n_bad++; $display("FAIL syscall_cause got %h want 80000020", cp0_cause); end
    n_cmp++; if (cp0_status[1] !== 1'b1) begin n_bad++; $display("FAIL syscall_exl got %0b want 1", cp0_status[1]); end
  endtask

  task automatic test_adel();
    do_reset();
    wb_valid = 1; wb_cp0_ex = 1; wb_excode = 5'd4; wb_badvaddr = 32'h3; wb_pc = 32'h8000_1000;
    tick();
    clear_inputs();
    cp0_raddr = 5'd8;
    #1;
    n_cmp++; if (cp0_rdata !== 32'h3) begin n_bad++; $display("FAIL adel_badvaddr got %h want 3", cp0_rdata); end
    n_cmp++; if (cp0_cause[6:2] !== 5'd4) begin n_bad++; $display("FAIL adel_code got %0d want 4", cp0_cause[6:2]); end
    n_cmp++; if (cp0_epc !== 32'h8000_1000) begin n_bad++; $display("FAIL adel_epc got %h want 80001000", cp0_epc); end
    wb_valid = 1; wb_cp0_ex = 1; wb_excode = 5'd8; wb_badvaddr = 32'h55; wb_pc = 32'h8000_2000; wb_bd = 1;
    tick();
    clear_inputs();
    cp0_raddr = 5'd8;
    #1;
    n_cmp++; if (cp0_epc !== 32'h8000_1000) begin n_bad++; $display("FAIL nested_epc got %h want 80001000", cp0_epc); end
    n_cmp++; if (cp0_cause[31] !== 1'b0 || cp0_cause[6:2] !== 5'd8) begin n_bad++; $display("FAIL nested_cause got %h want bd=0 code=8", cp0_cause); end
    n_cmp++; if (cp0_rdata !== 32'h3) begin n_bad++; $display("FAIL nested_badvaddr got %h want 3", cp0_rdata); end
  endtask

  task automatic test_eret();
    do_reset();
    mtc0(5'd14, 32'hBFC0_0200);
    mtc0(5'd12, 32'h0040_0002);
    wb_valid = 1; wb_eret = 1; wb_cp0_we = 1; wb_cp0_addr = 5'd14; wb_wdata = 32'h1234_5678;
    #1;
    n_cmp++; if (int_flush !== 1'b1 || flush_pc !== 32'hBFC0_0200) begin n_bad++; $display("FAIL eret_flush got %0b/%h want 1/bfc00200", int_flush, flush_pc); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (cp0_status[1] !== 1'b0) begin n_bad++; $display("FAIL eret_exl got %0b want 0", cp0_status[1]); end
    n_cmp++; if (cp0_epc !== 32'hBFC0_0200) begin n_bad++; $display("FAIL eret_epc got %h want bfc00200", cp0_epc); end
  endtask

  task automatic test_timer();
    do_reset();
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0040_8001);
    for (int i = 0; i < 8; i++) tick();
    cp0_raddr = 5'd9;
    #1;
    n_cmp++; if (cp0_rdata !== 32'd5) begin n_bad++; $display("FAIL timer_count got %0d want 5", cp0_rdata); end
    n_cmp++; if (cp0_cause[30] !== 1'b0) begin n_bad++; $display("FAIL timer_ti_early got %0b want 0", cp0_cause[30]); end
    tick();
    n_cmp++; if (cp0_cause[30] !== 1'b1 || cp0_cause[15] !== 1'b1) begin n_bad++; $display("FAIL timer_ti got ti=%0b ip7=%0b want 1/1", cp0_cause[30], cp0_cause[15]); end
    wb_valid = 1;
    #1;
    n_cmp++; if (int_flush !== 1'b1 || flush_pc !== VEC) begin n_bad++; $display("FAIL timer_int_flush got %0b/%h want 1/%h", int_flush, flush_pc, VEC); end
    tick();
    clear_inputs();
    #1;
    n_cmp++; if (cp0_cause[6:2] !== 5'd0 || cp0_status[1] !== 1'b1) begin n_bad++; $display("FAIL timer_int_code got code=%0d exl=%0b want 0/1", cp0_cause[6:2], cp0_status[1]); end
    mtc0(5'd11, 32'd0);
    #1;
    n_cmp++; if (cp0_cause[30] !== 1'b0) begin n_bad++; $display("FAIL timer_ti_clear got %0b want 0", cp0_cause[30]); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    mtc0(5'd9, 32'hFFFF_FFFF);
    cp0_raddr = 5'd9;
    #1;
    n_cmp++; if (cp0_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_load got %h want ffffffff", cp0_rdata); end
    tick();
    n_cmp++; if (cp0_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_hold got %h want ffffffff", cp0_rdata); end
    tick();
    n_cmp++; if (cp0_rdata !== 32'd0) begin n_bad++; $display("FAIL wrap_zero got %h want 0", cp0_rdata); end
    mtc0(5'd9, 32'd100);
    tick();
    mtc0(5'd9, 32'd7);
    cp0_raddr = 5'd9;
    #1;
    n_cmp++; if (cp0_rdata !== 32'd7) begin n_bad++; $display("FAIL count_collide got %0d want 7", cp0_rdata); end
  endtask

  task automatic test_random();
    logic [4:0] addrs [7];
    logic [4:0] codes [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd13, 5'd9};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      reset       = ($urandom_range(0, 299) == 0);
      wb_valid    = ($urandom_range(0, 3) != 0);
      wb_cp0_ex   = ($urandom_range(0, 15) == 0);
      wb_excode   = codes[$urandom_range(0, 7)];
      wb_pc       = {$urandom(), 2'b00} >> 2 << 2;
      wb_badvaddr = $urandom();
      wb_bd       = $urandom_range(0, 1);
      wb_cp0_we   = ($urandom_range(0, 2) == 0);
      wb_cp0_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : addrs[$urandom_range(0, 5)];
      wb_wdata    = $urandom();
      if (wb_cp0_addr == 5'd11) wb_wdata = $urandom_range(1, 60);
      if (wb_cp0_addr == 5'd9)  wb_wdata = m_cmp - $urandom_range(0, 3);
      if (wb_cp0_addr == 5'd12 && $urandom_range(0, 1) == 1) wb_wdata[1] = 1'b0;
      wb_eret     = ($urandom_range(0, 11) == 0);
      ext_int     = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'd0;
      cp0_raddr   = ($urandom_range(0, 4) == 0) ? 5'($urandom()) : addrs[$urandom_range(0, 6)];
      #1;
      n_cmp++; if (int_flush !== m_flush()) begin n_bad++; $display("FAIL rnd_flush[%0d] got %0b want %0b", i, int_flush, m_flush()); end
      n_cmp++; if (flush_pc !== m_flush_pc()) begin n_bad++; $display("FAIL rnd_flush_pc[%0d] got %h want %h", i, flush_pc, m_flush_pc()); end
      n_cmp++; if (cp0_status !== m_status()) begin n_bad++; $display("FAIL rnd_status[%0d] got %h want %h", i, cp0_status, m_status()); end
      n_cmp++; if (cp0_cause !== m_cause()) begin n_bad++; $display("FAIL rnd_cause[%0d] got %h want %h", i, cp0_cause, m_cause()); end
      n_cmp++; if (cp0_epc !== m_epc) begin n_bad++; $display("FAIL rnd_epc[%0d] got %h want %h", i, cp0_epc, m_epc); end
      n_cmp++; if (cp0_rdata !== m_read(cp0_raddr)) begin n_bad++; $display("FAIL rnd_read[%0d] addr %0d got %h want %h", i, cp0_raddr, cp0_rdata, m_read(cp0_raddr)); end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    #1;
    test_reset();
    test_syscall();
    test_adel();
    test_eret();
    test_timer();
    test_count_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
